// File: rtl/insn_aligner_if.sv
//------------------------------------------------------------------------------
// Module  : insn_aligner_if
// Brief   : Insn-buffer read port and decode-side record bus of the aligner.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface insn_aligner_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  flush;
    logic                  entryValid;
    logic [ADDR_WIDTH-1:0] entryPc;
    logic [15:0]           entryInsn;
    logic                  entryFault;
    logic                  entryIntValid;
    logic [3:0]            entryIntCode;
    logic                  entryReady;
    logic                  outValid;
    logic                  outReady;
    logic [ADDR_WIDTH-1:0] outPc;
    logic [31:0]           outInsn;
    logic                  outCompressed;
    logic                  outTrapValid;
    logic                  outTrapIsInterrupt;
    logic [3:0]            outTrapCode;
    logic [ADDR_WIDTH-1:0] outTrapValue;

    modport master (
        output flush, entryValid, entryPc, entryInsn, entryFault,
               entryIntValid, entryIntCode, outReady,
        input  entryReady, outValid, outPc, outInsn, outCompressed,
               outTrapValid, outTrapIsInterrupt, outTrapCode, outTrapValue
    );

    modport slave (
        input  flush, entryValid, entryPc, entryInsn, entryFault,
               entryIntValid, entryIntCode, outReady,
        output entryReady, outValid, outPc, outInsn, outCompressed,
               outTrapValid, outTrapIsInterrupt, outTrapCode, outTrapValue
    );
endinterface

`default_nettype wire

// File: rtl/insn_aligner.sv
//------------------------------------------------------------------------------
// Module  : insn_aligner
// Brief   : Assembles insn-buffer halfwords into 16/32-bit instructions or traps.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module insn_aligner #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter logic [3:0]  INSN_FAULT_CODE = 4'd1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    insn_aligner_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HALF = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           hold_insn_q, hold_insn_d;
    logic [ADDR_WIDTH-1:0] hold_pc_q, hold_pc_d;
    logic                  out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
    logic [31:0]           out_insn_q, out_insn_d;
    logic                  out_comp_q, out_comp_d;
    logic                  trap_valid_q, trap_valid_d;
    logic                  trap_int_q, trap_int_d;
    logic [3:0]            trap_code_q, trap_code_d;
    logic [ADDR_WIDTH-1:0] trap_value_q, trap_value_d;
    logic                  w_can_load;
    logic                  w_pop;

    always_comb begin
        w_can_load   = !out_valid_q || bus.outReady;
        w_pop        = 1'b0;
        state_d      = state_q;
        hold_insn_d  = hold_insn_q;
        hold_pc_d    = hold_pc_q;
        out_valid_d  = out_valid_q && !bus.outReady;
        out_pc_d     = out_pc_q;
        out_insn_d   = out_insn_q;
        out_comp_d   = out_comp_q;
        trap_valid_d = trap_valid_q;
        trap_int_d   = trap_int_q;
        trap_code_d  = trap_code_q;
        trap_value_d = trap_value_q;

        if (!bus.flush && bus.entryValid) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.entryIntValid || bus.entryFault || (bus.entryInsn[1:0] != 2'b11)) begin
                        if (w_can_load) begin
                            w_pop        = 1'b1;
                            out_valid_d  = 1'b1;
                            out_pc_d     = bus.entryPc;
                            out_insn_d   = 32'h0;
                            out_comp_d   = 1'b0;
                            trap_valid_d = 1'b1;
                            trap_int_d   = 1'b0;
                            trap_code_d  = 4'h0;
                            trap_value_d = '0;
                            if (bus.entryIntValid) begin
                                trap_int_d  = 1'b1;
                                trap_code_d = bus.entryIntCode;
                            end else if (bus.entryFault) begin
                                trap_code_d  = INSN_FAULT_CODE;
                                trap_value_d = bus.entryPc;
                            end else begin
                                trap_valid_d = 1'b0;
                                out_insn_d   = {16'h0, bus.entryInsn};
                                out_comp_d   = 1'b1;
                            end
                        end
                    end else begin
                        // Low half is taken even under back-pressure; nothing is emitted yet.
                        w_pop       = 1'b1;
                        hold_insn_d = bus.entryInsn;
                        hold_pc_d   = bus.entryPc;
                        state_d     = ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (w_can_load) begin
                        w_pop        = 1'b1;
                        state_d      = ST_IDLE;
                        out_valid_d  = 1'b1;
                        out_pc_d     = hold_pc_q;
                        out_insn_d   = 32'h0;
                        out_comp_d   = 1'b0;
                        trap_valid_d = 1'b1;
                        trap_int_d   = 1'b0;
                        trap_code_d  = 4'h0;
                        trap_value_d = '0;
                        if (bus.entryIntValid) begin
                            trap_int_d  = 1'b1;
                            trap_code_d = bus.entryIntCode;
                        end else if (bus.entryFault) begin
                            trap_code_d  = INSN_FAULT_CODE;
                            trap_value_d = bus.entryPc;
                        end else begin
                            trap_valid_d = 1'b0;
                            out_insn_d   = {bus.entryInsn, hold_insn_q};
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            state_q      <= ST_IDLE;
            hold_insn_q  <= 16'h0;
            hold_pc_q    <= '0;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_insn_q   <= 32'h0;
            out_comp_q   <= 1'b0;
            trap_valid_q <= 1'b0;
            trap_int_q   <= 1'b0;
            trap_code_q  <= 4'h0;
            trap_value_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_insn_q  <= hold_insn_d;
            hold_pc_q    <= hold_pc_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_insn_q   <= out_insn_d;
            out_comp_q   <= out_comp_d;
            trap_valid_q <= trap_valid_d;
            trap_int_q   <= trap_int_d;
            trap_code_q  <= trap_code_d;
            trap_value_q <= trap_value_d;
        end
    end

    assign bus.entryReady         = w_pop && !rst;
    assign bus.outValid           = out_valid_q;
    assign bus.outPc              = out_pc_q;
    assign bus.outInsn            = out_insn_q;
    assign bus.outCompressed      = out_comp_q;
    assign bus.outTrapValid       = trap_valid_q;
    assign bus.outTrapIsInterrupt = trap_int_q;
    assign bus.outTrapCode        = trap_code_q;
    assign bus.outTrapValue       = trap_value_q;

endmodule

`default_nettype wire

// File: tb/tb_insn_aligner.sv
//------------------------------------------------------------------------------
// Module  : tb_insn_aligner
// Brief   : Directed and random checks of insn_aligner against a record model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_insn_aligner;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        comp;
        logic        tv;
        logic        ti;
        logic [3:0]  tc;
        logic [31:0] tval;
    } rec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    insn_aligner_if #(.ADDR_WIDTH(32)) bus ();

    insn_aligner #(
        .ADDR_WIDTH     (32),
        .INSN_FAULT_CODE(4'd1)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: the pending output record and the pending low halfword.
    rec_t        m_out;
    bit          m_held;
    logic [15:0] m_hinsn;
    logic [31:0] m_hpc;
    bit          m_popped;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic rec_t dut_rec();
        rec_t r;
        r.valid = bus.outValid;
        r.pc    = bus.outPc;
        r.insn  = bus.outInsn;
        r.comp  = bus.outCompressed;
        r.tv    = bus.outTrapValid;
        r.ti    = bus.outTrapIsInterrupt;
        r.tc    = bus.outTrapCode;
        r.tval  = bus.outTrapValue;
        return r;
    endfunction

    // Record the decode stage should see for an instruction/trap starting at pc.
    function automatic rec_t make_rec(input logic [31:0] pc, input logic [15:0] lo,
                                      input logic [15:0] hi, input logic [31:0] hipc,
                                      input bit is32, input bit flt, input bit iv,
                                      input logic [3:0] code);
        rec_t r = '0;
        r.valid = 1'b1;
        r.pc    = pc;
        if (iv) begin
            r.tv = 1'b1; r.ti = 1'b1; r.tc = code;
        end else if (flt) begin
            r.tv = 1'b1; r.tc = 4'd1; r.tval = is32 ? hipc : pc;
        end else if (is32) begin
            r.insn = {hi, lo};
        end else begin
            r.insn = {16'h0, lo}; r.comp = 1'b1;
        end
        return r;
    endfunction

    task automatic cyc(input bit ev, input logic [31:0] pc, input logic [15:0] insn,
                       input bit flt, input bit iv, input logic [3:0] code,
                       input bit ordy, input bit fl);
        bit          exp_rdy;
        bit          free;
        rec_t        nxt;
        bit          n_held;
        logic [15:0] n_hinsn;
        logic [31:0] n_hpc;
        @(negedge clk);
        bus.entryValid    = ev;
        bus.entryPc       = pc;
        bus.entryInsn     = insn;
        bus.entryFault    = flt;
        bus.entryIntValid = iv;
        bus.entryIntCode  = code;
        bus.outReady      = ordy;
        bus.flush         = fl;
        #1;
        free    = !m_out.valid || ordy;
        exp_rdy = 1'b0;
        nxt     = m_out;
        if (ordy) nxt.valid = 1'b0;
        n_held  = m_held;
        n_hinsn = m_hinsn;
        n_hpc   = m_hpc;
        if (fl) begin
            nxt = '0; n_held = 1'b0; n_hinsn = '0; n_hpc = '0;
        end else if (ev) begin
            if (!m_held) begin
                if (!iv && !flt && insn[1:0] == 2'b11) begin
                    exp_rdy = 1'b1; n_held = 1'b1; n_hinsn = insn; n_hpc = pc;
                end else if (free) begin
                    exp_rdy = 1'b1;
                    nxt = make_rec(pc, insn, 16'h0, 32'h0, 1'b0, flt, iv, code);
                end
            end else if (free) begin
                exp_rdy = 1'b1; n_held = 1'b0;
                nxt = make_rec(m_hpc, m_hinsn, insn, pc, 1'b1, flt, iv, code);
            end
        end
        chk("entryReady", {127'h0, bus.entryReady}, {127'h0, exp_rdy});
        @(posedge clk);
        #1;
        m_out = nxt; m_held = n_held; m_hinsn = n_hinsn; m_hpc = n_hpc;
        m_popped = exp_rdy;
        chk("outValid", {127'h0, bus.outValid}, {127'h0, m_out.valid});
        if (m_out.valid) chk("record", {25'h0, dut_rec()}, {25'h0, m_out});
    endtask

    logic [31:0] h_pc;
    logic [15:0] h_insn;
    bit          h_flt, h_iv;
    logic [3:0]  h_code;

    task automatic new_head();
        h_pc   = ($urandom_range(0, 15) == 0) ? ({$urandom} & 32'hFFFF_FFFE) : h_pc + 32'd2;
        h_insn = $urandom;
        if ($urandom_range(0, 1) == 0) h_insn[1:0] = 2'b11;
        h_flt  = ($urandom_range(0, 15) == 0);
        h_iv   = ($urandom_range(0, 15) == 0);
        h_code = $urandom;
    endtask

    initial begin
        total = 0; bad = 0;
        m_out = '0; m_held = 1'b0; m_hinsn = '0; m_hpc = '0; m_popped = 1'b0;
        bus.flush = 1'b0; bus.entryValid = 1'b1; bus.entryPc = 32'h8000_0000;
        bus.entryInsn = 16'h4501; bus.entryFault = 1'b0; bus.entryIntValid = 1'b0;
        bus.entryIntCode = 4'h0; bus.outReady = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_entryReady", {127'h0, bus.entryReady}, 128'h0);
        @(posedge clk);
        #1;
        chk("rst_record", {25'h0, dut_rec()}, 128'h0);
        @(negedge clk);
        rst = 1'b0;

        // RVC stream
        cyc(1, 32'h8000_0000, 16'h4501, 0, 0, 0, 1, 0);
        chk("rvc0_insn", {96'h0, bus.outInsn}, {96'h0, 32'h0000_4501});
        chk("rvc0_comp", {127'h0, bus.outCompressed}, 128'h1);
        cyc(1, 32'h8000_0002, 16'h0505, 0, 0, 0, 1, 0);
        chk("rvc1_insn", {96'h0, bus.outInsn}, {96'h0, 32'h0000_0505});
        // 32-bit instruction
        cyc(1, 32'h8000_0000, 16'h0093, 0, 0, 0, 1, 0);
        chk("lo_no_out", {127'h0, bus.outValid}, 128'h0);
        cyc(1, 32'h8000_0002, 16'h0010, 0, 0, 0, 1, 0);
        chk("i32_insn", {96'h0, bus.outInsn}, {96'h0, 32'h0010_0093});
        chk("i32_pc", {96'h0, bus.outPc}, {96'h0, 32'h8000_0000});
        chk("i32_comp", {127'h0, bus.outCompressed}, 128'h0);
        // Fault on upper half
        cyc(1, 32'h8000_0004, 16'h0093, 0, 0, 0, 1, 0);
        cyc(1, 32'h8000_0006, 16'h0000, 1, 0, 0, 1, 0);
        chk("flt_code", {124'h0, bus.outTrapCode}, 128'h1);
        chk("flt_value", {96'h0, bus.outTrapValue}, {96'h0, 32'h8000_0006});
        chk("flt_pc", {96'h0, bus.outPc}, {96'h0, 32'h8000_0004});
        // Interrupt tag in IDLE
        cyc(1, 32'h8000_0010, 16'h4501, 0, 1, 4'd7, 1, 0);
        chk("int_flags", {125'h0, bus.outTrapValid, bus.outTrapIsInterrupt, bus.outCompressed}, 128'h6);
        chk("int_code", {124'h0, bus.outTrapCode}, 128'h7);
        chk("int_value", {96'h0, bus.outTrapValue}, 128'h0);
        // Stall with a pending record
        cyc(1, 32'h8000_0020, 16'h0093, 0, 0, 0, 0, 0);
        cyc(1, 32'h8000_0022, 16'h0010, 0, 0, 0, 0, 0);
        chk("stall_pc", {96'h0, bus.outPc}, {96'h0, 32'h8000_0010});
        cyc(1, 32'h8000_0022, 16'h0010, 0, 0, 0, 1, 0);
        chk("stall_insn", {96'h0, bus.outInsn}, {96'h0, 32'h0010_0093});
        // Flush in HALF with a pending record
        cyc(1, 32'h8000_0030, 16'h0093, 0, 0, 0, 0, 0);
        cyc(1, 32'h8000_0032, 16'h0010, 0, 0, 0, 1, 1);
        chk("flush_valid", {127'h0, bus.outValid}, 128'h0);
        cyc(1, 32'h8000_0040, 16'h4501, 0, 0, 0, 1, 0);
        chk("flush_rvc", {95'h0, bus.outCompressed, bus.outInsn}, {95'h0, 1'b1, 32'h0000_4501});

        // Random traffic; the head entry stays put until it is popped.
        h_pc = 32'h8000_0100;
        new_head();
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 4) != 0, h_pc, h_insn, h_flt, h_iv, h_code,
                $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
            if (m_popped) new_head();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/insn_aligner.md
# insn_aligner

Reads halfword entries (pc, 16-bit insn, fault, interrupt tag) from the insn buffer and assembles them into aligned 32-bit or 16-bit (RVC) instructions for the decode stage. It sits between the insn buffer read port and decode. It converts fault and interrupt tags into a TrapInfo-style trap record. It is the consumer-side counterpart of the fetch unit that fills the insn buffer.

## Interface
- ADDR_WIDTH, 32, pc / trap value width
- INSN_FAULT_CODE, 4'd1, exception code emitted for an entry with fault=1 (instruction access fault)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard held halfword and output register; no entry consumed this cycle
- entryValid  in  1  insn buffer head entry valid
- entryPc  in  ADDR_WIDTH  halfword address
- entryInsn  in  16  halfword
- entryFault  in  1  fetch fault on this halfword
- entryIntValid  in  1  interrupt tagged on this halfword
- entryIntCode  in  4  interrupt code
- entryReady  out  1  pop head entry this cycle (combinational)
- outValid  out  1  instruction/trap record valid (registered)
- outReady  in  1  decode accepts record
- outPc  out  ADDR_WIDTH  pc of first halfword
- outInsn  out  32  instruction; RVC zero-extended to 32 bits
- outCompressed  out  1  1 = 16-bit instruction
- outTrapValid  out  1  record is a trap, not an instruction
- outTrapIsInterrupt  out  1  1 = interrupt, 0 = exception
- outTrapCode  out  4  interrupt or exception code
- outTrapValue  out  ADDR_WIDTH  trap value (faulting halfword address; 0 for interrupt)

## Operation
- State: IDLE (no held halfword) and HALF (low halfword of a 32-bit insn held in holdInsn and holdPc).
- canLoad = !outValid || outReady. Output registers load only when canLoad.
- IDLE, entryValid, priority order:
  - entryIntValid: emit trap with isInterrupt=1, code=entryIntCode, pc=entryPc, value=0, insn=0. Consume. Requires canLoad.
  - entryFault: emit exception with code=INSN_FAULT_CODE, pc=entryPc, value=entryPc. Consume. Requires canLoad.
  - entryInsn[1:0] != 2'b11: emit outInsn={16'h0, entryInsn}, outCompressed=1, pc=entryPc. Consume. Requires canLoad.
  - Otherwise: latch holdInsn=entryInsn and holdPc=entryPc, then go to HALF. No output is produced. Consume regardless of canLoad.
- HALF, entryValid, canLoad: consume, then go to IDLE, with priority order:
  - entryIntValid: interrupt trap, pc=holdPc, value=0.
  - entryFault: exception INSN_FAULT_CODE, pc=holdPc, value=entryPc (upper-half address).
  - Otherwise: outInsn={entryInsn, holdInsn}, outCompressed=0, pc=holdPc.
- HALF with !canLoad: entryReady=0, state holds.
- entryReady = entryValid && !rst && !flush && (the consuming condition above).
- When outValid && !outReady, all out* fields are held stable.
- When outReady && no new load, outValid falls next cycle.
- No other pc arithmetic; continuity between halves is fetch's responsibility.

## Timing
- Reset (and flush), next edge: state=IDLE, outValid=0, all out* fields=0, holdInsn=0, holdPc=0.
- entryReady is 0 during the rst cycle.
- Flush beats every other event in the same cycle, including outReady and entryValid. The held halfword is lost; the in-flight output record is dropped.
- Latency: RVC, trap, or the upper half of a 32-bit insn consumed at edge N gives outValid from cycle N+1.
- Throughput: one RVC per cycle; one 32-bit insn per two cycles (single read port).
- Back-pressure: in IDLE with a 32-bit low half, the half is accepted even while the output is stalled. The next entry then waits in HALF until canLoad.
- Simultaneous outReady and new load: the old record retires and the new one appears next cycle with no bubble.

## Test plan
- RVC stream, outReady=1: entries pc 0x80000000 insn 0x4501, then 0x80000002 insn 0x0505 → two consecutive records, outCompressed=1, outInsn 0x00004501 then 0x00000505, 1-cycle latency each.
- 32-bit insn: 0x80000000 insn 0x0093 then 0x80000002 insn 0x0010 → one record, pc 0x80000000, outInsn 0x00100093, outCompressed=0, valid the cycle after the second pop.
- Fault on upper half: low 0x0093 @0x80000004, high fault @0x80000006 → trap: isInterrupt=0, code=1, pc 0x80000004, value 0x80000006.
- Interrupt tag: entryIntValid=1, code 7 @0x80000010 in IDLE → trap: isInterrupt=1, code=7, value=0, pc 0x80000010.
- Stall: outReady=0 with record pending; feed 0x0093 then 0x0010 → low half popped, entryReady=0 for the high half, outputs stable. Raise outReady → 0x00100093 emitted next cycle.
- Flush in HALF with outValid=1: next cycle outValid=0 and state IDLE. A following RVC 0x4501 is emitted as compressed, with no stale half merged in.
